// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag layout,
// FSM state encoding and the legal-opcode check.
package alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 6;

  localparam logic [DEF_OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [DEF_OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [DEF_OP_W-1:0] OP_AND = 6'h24;
  localparam logic [DEF_OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [DEF_OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [DEF_OP_W-1:0] OP_NOR = 6'h27;
  localparam logic [DEF_OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [DEF_OP_W-1:0] OP_SRL = 6'h02;

  localparam int FLG_Z   = 0;
  localparam int FLG_C   = 1;
  localparam int FLG_ILL = 2;

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_GET_OP,
    ST_EXEC,
    ST_SEND_RES,
    ST_SEND_FLG
  } seq_state_t;

  function automatic logic op_legal(input logic [DEF_OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_timeout.sv
// Inter-byte idle counter: counts while run is high and nothing clears it,
// and flags expiry on the last allowed idle cycle.
module alu_cmd_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = run && (cnt == LAST);

  // Clearing at expiry keeps the counter from ever wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr || !run || expire) cnt <= '0;
    else                              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream front end for the 8-bit ALU: gathers A, B, OP, runs one EXEC
// cycle, then returns a result byte and a flags byte.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_rdo,
  input  logic              alu_carry,
  input  logic              alu_zero
);

  seq_state_t state, state_nxt;

  logic              xfer_in, xfer_out;
  logic              ld_a, ld_b, ld_op, cap;
  logic              tmo_run, tmo_expire;
  logic              illegal_p0;
  logic [DATA_W-1:0] res_p1, flg_p1, flg_nxt;
  logic [OP_W-1:0]   op_in;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;
  assign op_in    = in_data[OP_W-1:0];
  assign tmo_run  = (state == ST_GET_B) || (state == ST_GET_OP);

  alu_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (tmo_run),
    .clr    (xfer_in),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    cap       = 1'b0;
    case (state)
      ST_GET_A: begin
        in_ready = !rst;
        ld_a     = xfer_in;
        if (xfer_in) state_nxt = ST_GET_B;
      end
      ST_GET_B: begin
        in_ready = !rst;
        ld_b     = xfer_in;
        if (xfer_in)         state_nxt = ST_GET_OP;
        else if (tmo_expire) state_nxt = ST_GET_A;
      end
      ST_GET_OP: begin
        in_ready = !rst;
        ld_op    = xfer_in;
        if (xfer_in)         state_nxt = ST_EXEC;
        else if (tmo_expire) state_nxt = ST_GET_A;
      end
      ST_EXEC: begin
        cap       = 1'b1;
        state_nxt = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        out_valid = 1'b1;
        out_data  = res_p1;
        if (xfer_out) state_nxt = ST_SEND_FLG;
      end
      ST_SEND_FLG: begin
        out_valid = 1'b1;
        out_data  = flg_p1;
        if (xfer_out) state_nxt = ST_GET_A;
      end
      default: state_nxt = ST_GET_A;
    endcase
  end

  always_comb begin
    flg_nxt          = '0;
    flg_nxt[FLG_Z]   = alu_zero;
    flg_nxt[FLG_C]   = alu_carry;
    flg_nxt[FLG_ILL] = illegal_p0;
  end

  // Stage p0: operand/opcode registers presented to the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_GET_A;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else begin
      state <= state_nxt;
      if (ld_a)  alu_a  <= in_data;
      if (ld_b)  alu_b  <= in_data;
      if (ld_op) alu_op <= op_in;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_op) illegal_p0 <= !op_legal(DEF_OP_W'(op_in));
  end

  // Stage p1: ALU result and flags captured during EXEC.
  always_ff @(posedge clk) begin
    if (cap) begin
      res_p1 <= alu_rdo;
      flg_p1 <= flg_nxt;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU on its alu_* ports.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] alu_a, alu_b, alu_rdo;
  logic [5:0] alu_op;
  logic       alu_carry, alu_zero;
  logic [8:0] m_r9;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(8), .OP_W(6), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_rdo   (alu_rdo),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero)
  );

  // ALU model: shifts move A by one bit; unknown opcodes yield zero.
  always_comb begin
    m_r9 = '0;
    case (alu_op)
      6'h20: m_r9 = {1'b0, alu_a} + {1'b0, alu_b};
      6'h22: m_r9 = {1'b0, alu_a} - {1'b0, alu_b};
      6'h24: m_r9 = {1'b0, alu_a & alu_b};
      6'h25: m_r9 = {1'b0, alu_a | alu_b};
      6'h26: m_r9 = {1'b0, alu_a ^ alu_b};
      6'h27: m_r9 = {1'b0, ~(alu_a | alu_b)};
      6'h03: m_r9 = {1'b0, 8'($signed(alu_a) >>> 1)};
      6'h02: m_r9 = {1'b0, alu_a >> 1};
      default: m_r9 = '0;
    endcase
  end
  assign alu_rdo   = m_r9[7:0];
  assign alu_carry = m_r9[8];
  assign alu_zero  = (m_r9[7:0] == 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk({tag, "_wait"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  // Called in the EXEC cycle, right after the OP byte has transferred.
  task automatic finish_frame(input logic [7:0] ea, eb, input logic [5:0] eop,
                              input logic [7:0] eres, eflg);
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_op", 32'(alu_op), 32'(eop));
    chk("exec_out_valid", 32'(out_valid), 32'd0);
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    get_byte("res", eres);
    get_byte("flg", eflg);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] a, b, op, input logic [5:0] eop,
                           input logic [7:0] eres, eflg);
    put_byte(a);
    put_byte(b);
    put_byte(op);
    finish_frame(a, b, eop, eres, eflg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Basic opcodes
    run_frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00);
    run_frame(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 8'h02);
    run_frame(8'hF0, 8'h0F, 8'h24, 6'h24, 8'h00, 8'h01);
    run_frame(8'h81, 8'h00, 8'hC3, 6'h03, 8'hC0, 8'h00);
    run_frame(8'h12, 8'h34, 8'h3F, 6'h3F, 8'h00, 8'h05);

    // Backpressure with an upstream byte held during the response
    out_ready = 1'b0;
    put_byte(8'h0A);
    put_byte(8'h05);
    put_byte(8'h20);
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h0F);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    get_byte("bp_res", 8'h0F);
    get_byte("bp_flg", 8'h00);
    put_byte(8'h99);
    put_byte(8'h01);
    put_byte(8'h20);
    finish_frame(8'h99, 8'h01, 6'h20, 8'h9A, 8'h00);

    // Byte arriving on the expiry cycle is still accepted
    put_byte(8'h10);
    repeat (7) @(negedge clk);
    put_byte(8'h20);
    put_byte(8'h20);
    finish_frame(8'h10, 8'h20, 6'h20, 8'h30, 8'h00);

    // Timeout in GET_B
    put_byte(8'h11);
    repeat (8) @(negedge clk);
    chk("tmo_b_alu_a", 32'(alu_a), 32'h11);
    chk("tmo_b_out_valid", 32'(out_valid), 32'd0);
    run_frame(8'h01, 8'h01, 8'h20, 6'h20, 8'h02, 8'h00);

    // Timeout in GET_OP
    put_byte(8'h07);
    put_byte(8'h07);
    repeat (8) @(negedge clk);
    chk("tmo_op_alu_b", 32'(alu_b), 32'h07);
    chk("tmo_op_alu_op", 32'(alu_op), 32'h20);
    run_frame(8'h02, 8'h03, 8'h20, 6'h20, 8'h05, 8'h00);

    // Reset during SEND_FLG
    put_byte(8'h40);
    put_byte(8'h01);
    put_byte(8'h20);
    @(negedge clk);
    get_byte("pre_rst_res", 8'h41);
    chk("pre_rst_flg_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_data", 32'(out_data), 32'd0);
    chk("rst2_alu_a", 32'(alu_a), 32'd0);
    chk("rst2_alu_b", 32'(alu_b), 32'd0);
    chk("rst2_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(8'h02, 8'h02, 8'h26, 6'h26, 8'h00, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Drives the ALU's operand/op inputs from a byte stream and returns the ALU's result as bytes; it is the command-side counterpart of the 8-bit ALU.
- Sits between a byte receiver (UART RX side) and a byte transmitter (UART TX side).
- Collects A, B and OP bytes, presents them to the ALU as registers, captures rdo/carry/zero, then emits a result byte and a flags byte.
- An inter-byte timeout discards partial commands.

Parameters:
- DATA_W, 8, data width of operands, result and byte streams.
- OP_W, 6, ALU opcode width; the low OP_W bits of the op byte are used.
- TIMEOUT, 50000, idle clk cycles allowed between command bytes before the frame is discarded (must be >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  command byte from receiver.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts in_data this cycle.
- out_data  out  DATA_W  response byte to transmitter.
- out_valid  out  1  out_data valid.
- out_ready  in  1  transmitter accepts out_data this cycle.
- alu_a  out  DATA_W  registered operand A to ALU.
- alu_b  out  DATA_W  registered operand B to ALU.
- alu_op  out  OP_W  registered opcode to ALU.
- alu_rdo  in  DATA_W  ALU result.
- alu_carry  in  1  ALU carry (bit 8 of internal result).
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Reset (one clk with rst=1): state=GET_A; alu_a=0, alu_b=0, alu_op=0; out_valid=0, out_data=0; in_ready=0 for that cycle; timeout counter=0. Reset overrides everything, including mid-frame and mid-send; any partial frame or pending byte is dropped.
- A byte transfers on a clk edge where valid && ready.
- States and transitions:
  - GET_A: in_ready=1. On transfer, alu_a<=in_data and go to GET_B.
  - GET_B: in_ready=1. On transfer, alu_b<=in_data and go to GET_OP.
  - GET_OP: in_ready=1. On transfer, alu_op<=in_data[OP_W-1:0] (upper bits ignored), latch illegal=(op not in {0x20,0x22,0x24,0x25,0x26,0x27,0x03,0x02}), and go to EXEC.
  - EXEC: exactly 1 cycle, in_ready=0. Capture res<=alu_rdo and flags<={0..., illegal, alu_carry, alu_zero} (bit0=zero, bit1=carry, bit2=illegal, others 0). Go to SEND_RES.
  - SEND_RES: out_valid=1, out_data=res. On transfer go to SEND_FLG.
  - SEND_FLG: out_valid=1, out_data=flags. On transfer go to GET_A.
- Latency: the first response byte is valid 2 clks after the OP byte transfer edge, i.e. the cycle after EXEC.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid stay stable. alu_* stay stable from the OP transfer until the next A transfer.
- in_ready=0 in EXEC, SEND_RES and SEND_FLG. Bytes offered there are not consumed; the upstream side holds them.
- Timeout: the counter runs only in GET_B and GET_OP while no transfer occurs, and clears on any transfer or state change.
  - When it reaches TIMEOUT-1 with no transfer that cycle, go to GET_A. No output is produced and alu_* keep their values.
  - A transfer in the same cycle as expiry wins: the byte is accepted and the FSM advances normally.
- Illegal op: the ALU is still driven. Its rdo (0x00) and zero are reported as-is, with flags bit2 set.
- Counter width is clog2(TIMEOUT). No wrap-around is possible because the counter clears at expiry.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and OP_W defaults.
  - Opcode constants OP_ADD=6'h20, OP_SUB=6'h22, OP_AND=6'h24, OP_OR=6'h25, OP_XOR=6'h26, OP_NOR=6'h27, OP_SRA=6'h03, OP_SRL=6'h02.
  - Flag bit indices FLG_Z=0, FLG_C=1, FLG_ILL=2.
  - The FSM state encoding.
- One natural sub-module: alu_cmd_timeout (load/clear/expire counter).
- The legal-op check is a function in alu_pkg.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with out_ready=1 -> alu_a=0x05, alu_b=0x03, alu_op=0x20; out bytes 0x08 then 0x00; first out_valid exactly 2 clks after the OP transfer.
- Bytes 0x03, 0x05, 0x22 -> out 0xFE, 0x02 (carry). Then 0xF0, 0x0F, 0x24 -> out 0x00, 0x01 (zero).
- Bytes 0x81, 0x00, 0xC3 (op 0x03 after masking) -> alu_op=0x03, out 0xC0, 0x00.
- Bytes 0x12, 0x34, 0x3F -> out 0x00, 0x05 (illegal + zero).
- out_ready held low 10 clks in SEND_RES -> out_data=result stays stable, in_ready=0; releasing it delivers 2 bytes in order.
- With TIMEOUT=8: send 0x11, then idle 8 clks -> state back to GET_A. Next bytes 0x01, 0x01, 0x20 -> out 0x02, 0x00. Assert rst during SEND_FLG -> out_valid=0 next clk and all outputs zeroed.
